// File: rtl/vsc8541_smi_pkg.sv
// Shared types and constants for the VSC8541 SMI controller and its MDIO frame engine.
package vsc8541_smi_pkg;

    localparam int SMI_PHY_W  = 5;
    localparam int SMI_REG_W  = 5;
    localparam int SMI_DATA_W = 16;
    localparam int SMI_CNT_W  = 8;

    localparam logic [SMI_REG_W-1:0] SMI_REG_STATUS = 5'h01;
    localparam int                   SMI_LINK_BIT   = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_GAP
    } smi_state_t;

    function automatic logic [SMI_CNT_W-1:0] cnt_sat_inc(input logic [SMI_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vsc8541_smi_rr_arb.sv
// Combinational round-robin pick: first set request at or after rr_ptr, cyclically.
module vsc8541_smi_rr_arb #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    localparam logic [IW:0] N_W = (IW+1)'(NREQ);

    logic [NREQ-1:0] rot;
    logic [IW:0]     pos;

    always_comb begin
        rot = NREQ'({req, req} >> rr_ptr);
        gnt = '0;
        any = 1'b0;
        pos = '0;
        // Walk downward so the lowest rotated position wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = {1'b0, rr_ptr} + (IW+1)'(i);
                any = 1'b1;
            end
        end
        if (pos >= N_W) begin
            pos = pos - N_W;
        end
        idx = pos[IW-1:0];
        if (any) begin
            gnt = NREQ'(1) << idx;
        end
    end

endmodule

// File: rtl/vsc8541_smi_ctrl.sv
// Round-robin SMI access sequencer in front of the MDIO frame engine.
// Optional autonomous link polling is enabled with `define VSC8541_SMI_CTRL_POLL_EN.
module vsc8541_smi_ctrl
    import vsc8541_smi_pkg::*;
#(
    parameter int                   NREQ          = 2,
    parameter int                   WR_EDGES      = 32,
    parameter int                   RD_TIMEOUT    = 64,
    parameter int                   GAP_EDGES     = 2,
    parameter int                   POLL_INTERVAL = 1_000_000,
    parameter logic [SMI_PHY_W-1:0] POLL_PHY_ADDR = 5'h00
) (
    input  logic                                 clk,
    input  logic                                 i_reset,
    input  logic                                 i_mdc,
    input  logic [NREQ-1:0]                      i_req,
    input  logic [NREQ-1:0]                      i_req_mode,
    input  logic [NREQ-1:0][SMI_PHY_W-1:0]       i_req_phy_addr,
    input  logic [NREQ-1:0][SMI_REG_W-1:0]       i_req_reg_addr,
    input  logic [NREQ-1:0][SMI_DATA_W-1:0]      i_req_data,
    output logic [NREQ-1:0]                      o_grant,
    output logic [NREQ-1:0]                      o_done,
    output logic [SMI_DATA_W-1:0]                o_rdata,
    output logic                                 o_err,
    output logic                                 o_busy,
    output logic                                 o_mdio_en,
    output logic                                 o_mdio_mode,
    output logic [SMI_PHY_W-1:0]                 o_mdio_phy_addr,
    output logic [SMI_REG_W-1:0]                 o_mdio_reg_addr,
    output logic [SMI_DATA_W-1:0]                o_mdio_data,
    input  logic                                 i_mdio_dv,
    input  logic [SMI_DATA_W-1:0]                i_mdio_data,
    output logic                                 o_link_up,
    output smi_state_t                           fsm_state
);

    localparam int                   IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [SMI_CNT_W-1:0] WR_LIM  = SMI_CNT_W'(WR_EDGES);
    localparam logic [SMI_CNT_W-1:0] RD_LIM  = SMI_CNT_W'(RD_TIMEOUT);
    localparam logic [SMI_CNT_W-1:0] GAP_LIM = SMI_CNT_W'(GAP_EDGES);
    localparam logic [IW-1:0]        LAST    = IW'(NREQ - 1);

    smi_state_t           state, state_nx;
    logic                 mdc_q, fall;
    logic [SMI_CNT_W-1:0] cnt, cnt_inc;
    logic [IW-1:0]        rr_ptr, sel_idx, arb_idx;
    logic [NREQ-1:0]      arb_gnt, sel_oh, grant_d, done_d;
    logic                 arb_any, is_poll, poll_pend, poll_take, start;
    logic                 wr_fin, rd_ok, rd_to, frame_fin, gap_fin, launch_d;

    vsc8541_smi_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req    (i_req),
        .rr_ptr (rr_ptr),
        .gnt    (arb_gnt),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    assign fall      = mdc_q & ~i_mdc;
    assign cnt_inc   = cnt_sat_inc(cnt);
    assign poll_take = (state == ST_IDLE) && !arb_any && poll_pend;
    assign start     = (state == ST_IDLE) && (arb_any || poll_pend);
    assign wr_fin    = fall && (cnt_inc >= WR_LIM);
    assign rd_ok     = (state == ST_WAIT) && !o_mdio_mode && i_mdio_dv;
    assign rd_to     = (state == ST_WAIT) && !o_mdio_mode && !i_mdio_dv && fall && (cnt_inc >= RD_LIM);
    assign frame_fin = o_mdio_mode ? wr_fin : (rd_ok || rd_to);
    assign gap_fin   = (cnt >= GAP_LIM) || (fall && (cnt_inc >= GAP_LIM));
    assign o_busy    = (state != ST_IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (start) state_nx = ST_LAUNCH;
            ST_LAUNCH: state_nx = ST_WAIT;
            ST_WAIT:   if (frame_fin) state_nx = ST_GAP;
            ST_GAP:    if (gap_fin) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Poll frames latch an all-zero sel_oh, which keeps them off o_grant/o_done.
    always_comb begin
        launch_d = (state == ST_LAUNCH);
        grant_d  = launch_d ? sel_oh : '0;
        done_d   = ((state == ST_WAIT) && frame_fin) ? sel_oh : '0;
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            mdc_q           <= 1'b0;
            cnt             <= '0;
            rr_ptr          <= '0;
            sel_idx         <= '0;
            sel_oh          <= '0;
            is_poll         <= 1'b0;
            o_grant         <= '0;
            o_done          <= '0;
            o_mdio_en       <= 1'b0;
            o_mdio_mode     <= 1'b0;
            o_mdio_phy_addr <= '0;
            o_mdio_reg_addr <= '0;
            o_mdio_data     <= '0;
            o_rdata         <= '0;
            o_err           <= 1'b0;
        end else begin
            mdc_q     <= i_mdc;
            o_grant   <= grant_d;
            o_done    <= done_d;
            o_mdio_en <= launch_d;
            if (start) begin
                is_poll <= poll_take;
                sel_idx <= arb_idx;
                if (poll_take) begin
                    sel_oh          <= '0;
                    o_mdio_mode     <= 1'b0;
                    o_mdio_phy_addr <= POLL_PHY_ADDR;
                    o_mdio_reg_addr <= SMI_REG_STATUS;
                    o_mdio_data     <= '0;
                end else begin
                    sel_oh          <= arb_gnt;
                    o_mdio_mode     <= i_req_mode[arb_idx];
                    o_mdio_phy_addr <= i_req_phy_addr[arb_idx];
                    o_mdio_reg_addr <= i_req_reg_addr[arb_idx];
                    o_mdio_data     <= i_req_data[arb_idx];
                end
            end
            if (launch_d && !is_poll) begin
                rr_ptr <= (sel_idx == LAST) ? '0 : sel_idx + 1'b1;
            end
            if (launch_d || ((state == ST_WAIT) && frame_fin)) begin
                cnt <= '0;
            end else if (fall) begin
                cnt <= cnt_inc;
            end
            if (rd_ok && !is_poll) begin
                o_rdata <= i_mdio_data;
            end
            if ((state == ST_WAIT) && frame_fin && !is_poll) begin
                o_err <= rd_to;
            end
        end
    end

`ifdef VSC8541_SMI_CTRL_POLL_EN
    logic [31:0] poll_cnt;

    // Arming wins over a same-cycle take so no interval is lost.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            poll_cnt  <= '0;
            poll_pend <= 1'b0;
            o_link_up <= 1'b0;
        end else begin
            if (poll_take) begin
                poll_pend <= 1'b0;
            end
            if (poll_cnt == 32'(POLL_INTERVAL - 1)) begin
                poll_cnt  <= '0;
                poll_pend <= 1'b1;
            end else begin
                poll_cnt <= poll_cnt + 32'd1;
            end
            if (is_poll && rd_ok) begin
                o_link_up <= i_mdio_data[SMI_LINK_BIT];
            end else if (is_poll && rd_to) begin
                o_link_up <= 1'b0;
            end
        end
    end
`else
    // No poll timer in this build; the interval only matters in the POLL build.
    assign poll_pend = (POLL_INTERVAL < 0);
    assign o_link_up = 1'b0;
`endif

endmodule

// File: tb/tb_vsc8541_smi_ctrl.sv
// Directed bench for vsc8541_smi_ctrl; the POLL section runs when VSC8541_SMI_CTRL_POLL_EN is defined.
`timescale 1ns/1ps
module tb_vsc8541_smi_ctrl;
    import vsc8541_smi_pkg::*;

    localparam int NREQ = 2;
`ifdef VSC8541_SMI_CTRL_POLL_EN
    localparam int POLL_IV = 2000;
`else
    localparam int POLL_IV = 1_000_000;
`endif

    logic                   clk = 1'b0;
    logic                   i_reset = 1'b1;
    logic                   i_mdc = 1'b0;
    logic [NREQ-1:0]        i_req = '0;
    logic [NREQ-1:0]        i_req_mode = '0;
    logic [NREQ-1:0][4:0]   i_req_phy_addr = '0;
    logic [NREQ-1:0][4:0]   i_req_reg_addr = '0;
    logic [NREQ-1:0][15:0]  i_req_data = '0;
    logic [NREQ-1:0]        o_grant, o_done;
    logic [15:0]            o_rdata;
    logic                   o_err, o_busy, o_mdio_en, o_mdio_mode, o_link_up;
    logic [4:0]             o_mdio_phy_addr, o_mdio_reg_addr;
    logic [15:0]            o_mdio_data;
    logic                   i_mdio_dv = 1'b0;
    logic [15:0]            i_mdio_data = '0;
    smi_state_t             fsm_state;

    int checks = 0;
    int failures = 0;
    int falls = 0;
    int mdc_div = 0;
    int pulse_cnt = 0;
    logic mdc_prev = 1'b0;

    vsc8541_smi_ctrl #(
        .NREQ(NREQ), .WR_EDGES(32), .RD_TIMEOUT(64), .GAP_EDGES(2),
        .POLL_INTERVAL(POLL_IV), .POLL_PHY_ADDR(5'h00)
    ) dut (
        .clk(clk), .i_reset(i_reset), .i_mdc(i_mdc),
        .i_req(i_req), .i_req_mode(i_req_mode),
        .i_req_phy_addr(i_req_phy_addr), .i_req_reg_addr(i_req_reg_addr),
        .i_req_data(i_req_data),
        .o_grant(o_grant), .o_done(o_done), .o_rdata(o_rdata), .o_err(o_err),
        .o_busy(o_busy), .o_mdio_en(o_mdio_en), .o_mdio_mode(o_mdio_mode),
        .o_mdio_phy_addr(o_mdio_phy_addr), .o_mdio_reg_addr(o_mdio_reg_addr),
        .o_mdio_data(o_mdio_data), .i_mdio_dv(i_mdio_dv), .i_mdio_data(i_mdio_data),
        .o_link_up(o_link_up), .fsm_state(fsm_state)
    );

    // Clock, MDC (4 clk period, changes on negedge) and falling-edge reference count
    always #5 clk = ~clk;

    always @(negedge clk) begin
        mdc_div = (mdc_div + 1) % 4;
        i_mdc = (mdc_div >= 2);
    end

    always @(posedge clk) begin
        if (mdc_prev && !i_mdc) falls++;
        mdc_prev = i_mdc;
    end

    always @(negedge clk) begin
        if (!i_reset && (o_grant != '0 || o_done != '0)) pulse_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int r, input logic mode, input logic [4:0] phy,
                             input logic [4:0] rga, input logic [15:0] d);
        @(negedge clk);
        i_req_mode[r] = mode;
        i_req_phy_addr[r] = phy;
        i_req_reg_addr[r] = rga;
        i_req_data[r] = d;
        i_req[r] = 1'b1;
    endtask

    task automatic wait_grant(output int lat);
        lat = 0;
        while (lat < 400) begin
            tick();
            lat++;
            if (o_grant != '0) return;
        end
        lat = -1;
    endtask

    task automatic wait_done(input int f0, output int edges);
        for (int k = 0; k < 600; k++) begin
            tick();
            if (o_done != '0) begin
                edges = falls - f0;
                return;
            end
        end
        edges = -1;
    endtask

    task automatic wait_idle(output int edges);
        int f0;
        f0 = falls;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (!o_busy) begin
                edges = falls - f0;
                return;
            end
        end
        edges = -1;
    endtask

    task automatic wait_en(output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (o_mdio_en) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic pulse_dv(input logic [15:0] d);
        @(negedge clk);
        i_mdio_dv = 1'b1;
        i_mdio_data = d;
        tick();
        @(negedge clk);
        i_mdio_dv = 1'b0;
        i_mdio_data = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int lat, e, g, fd, nd;
        logic ok;
        logic [1:0] exp_g [4];
        logic [15:0] exp_d [4];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_d = '{16'h1111, 16'h2222, 16'h1111, 16'h2222};

        repeat (3) tick();
        check_val("rst_grant", o_grant, 0);
        check_val("rst_done", o_done, 0);
        check_val("rst_busy", o_busy, 0);
        check_val("rst_en", o_mdio_en, 0);
        check_val("rst_rdata", o_rdata, 0);
        check_val("rst_err", o_err, 0);
        check_val("rst_link", o_link_up, 0);
        check_val("rst_phy", o_mdio_phy_addr, 0);
        check_val("rst_state", fsm_state, ST_IDLE);
        @(negedge clk);
        i_reset = 1'b0;

`ifdef VSC8541_SMI_CTRL_POLL_EN
        wait_en(ok);
        check_val("poll1_seen", ok, 1);
        check_val("poll1_reg", o_mdio_reg_addr, 5'h01);
        check_val("poll1_phy", o_mdio_phy_addr, 5'h00);
        check_val("poll1_mode", o_mdio_mode, 0);
        repeat (3) tick();
        pulse_dv(16'h0004);
        check_val("poll1_link", o_link_up, 1);
        wait_en(ok);
        check_val("poll2_seen", ok, 1);
        repeat (3) tick();
        pulse_dv(16'h0000);
        check_val("poll2_link", o_link_up, 0);
        repeat (20) tick();
        check_val("poll_no_pulses", pulse_cnt, 0);
`else
        // Single write from req0, with a stray dv inside the frame
        drive_req(0, 1'b1, 5'h05, 5'h1b, 16'ha55a);
        wait_grant(lat);
        g = falls;
        check_val("wr_grant_lat", lat, 2);
        check_val("wr_grant", o_grant, 2'b01);
        check_val("wr_en", o_mdio_en, 1);
        check_val("wr_mode", o_mdio_mode, 1);
        check_val("wr_phy", o_mdio_phy_addr, 5'h05);
        check_val("wr_reg", o_mdio_reg_addr, 5'h1b);
        check_val("wr_data", o_mdio_data, 16'ha55a);
        i_req[0] = 1'b0;
        tick();
        check_val("wr_grant_pulse", o_grant, 0);
        check_val("wr_busy", o_busy, 1);
        pulse_dv(16'h1234);
        wait_done(g, e);
        check_val("wr_edges", e, 32);
        check_val("wr_done", o_done, 2'b01);
        check_val("wr_rdata_kept", o_rdata, 0);
        check_val("wr_err", o_err, 0);
        wait_idle(e);
        check_val("wr_gap", e, 2);

        // Read from req1, data returned by dv
        drive_req(1, 1'b0, 5'h05, 5'h1b, 16'h0000);
        wait_grant(lat);
        check_val("rd_grant_lat", lat, 2);
        check_val("rd_grant", o_grant, 2'b10);
        check_val("rd_mode", o_mdio_mode, 0);
        i_req[1] = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        i_mdio_dv = 1'b1;
        i_mdio_data = 16'h5aa5;
        tick();
        check_val("rd_done", o_done, 2'b10);
        check_val("rd_rdata", o_rdata, 16'h5aa5);
        check_val("rd_err", o_err, 0);
        @(negedge clk);
        i_mdio_dv = 1'b0;
        i_mdio_data = '0;
        wait_idle(e);
        check_val("rd_gap", e, 2);

        // Read timeout
        drive_req(1, 1'b0, 5'h07, 5'h02, 16'h0000);
        wait_grant(lat);
        g = falls;
        check_val("to_grant", o_grant, 2'b10);
        i_req[1] = 1'b0;
        wait_done(g, e);
        check_val("to_edges", e, 64);
        check_val("to_done", o_done, 2'b10);
        check_val("to_err", o_err, 1);
        check_val("to_rdata_kept", o_rdata, 16'h5aa5);
        wait_idle(e);

        // Two persistent writers: round-robin with gaps
        @(negedge clk);
        i_req_mode = 2'b11;
        i_req_phy_addr[0] = 5'h01; i_req_reg_addr[0] = 5'h02; i_req_data[0] = 16'h1111;
        i_req_phy_addr[1] = 5'h03; i_req_reg_addr[1] = 5'h04; i_req_data[1] = 16'h2222;
        i_req = 2'b11;
        fd = 0;
        for (int k = 0; k < 4; k++) begin
            wait_grant(lat);
            g = falls;
            check_val($sformatf("rr_grant%0d", k), o_grant, exp_g[k]);
            check_val($sformatf("rr_data%0d", k), o_mdio_data, exp_d[k]);
            if (k > 0) check_val($sformatf("rr_gap%0d", k), g - fd, 2);
            if (k == 3) i_req = 2'b00;
            wait_done(g, e);
            fd = falls;
            check_val($sformatf("rr_done%0d", k), o_done, exp_g[k]);
            check_val($sformatf("rr_edges%0d", k), e, 32);
        end
        wait_idle(e);

        // Reset mid-WAIT aborts the access
        drive_req(0, 1'b1, 5'h09, 5'h03, 16'hbeef);
        wait_grant(lat);
        check_val("ab_grant", o_grant, 2'b01);
        i_req[0] = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        i_reset = 1'b1;
        tick();
        check_val("ab_busy", o_busy, 0);
        check_val("ab_grant0", o_grant, 0);
        check_val("ab_done0", o_done, 0);
        check_val("ab_en", o_mdio_en, 0);
        check_val("ab_mode", o_mdio_mode, 0);
        check_val("ab_phy", o_mdio_phy_addr, 0);
        check_val("ab_reg", o_mdio_reg_addr, 0);
        check_val("ab_data", o_mdio_data, 0);
        check_val("ab_rdata", o_rdata, 0);
        check_val("ab_err", o_err, 0);
        @(negedge clk);
        i_reset = 1'b0;
        nd = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (o_done != '0) nd++;
        end
        check_val("ab_no_done", nd, 0);
        drive_req(1, 1'b1, 5'h0a, 5'h0c, 16'hcafe);
        wait_grant(lat);
        g = falls;
        check_val("post_grant_lat", lat, 2);
        check_val("post_grant", o_grant, 2'b10);
        check_val("post_data", o_mdio_data, 16'hcafe);
        i_req[1] = 1'b0;
        wait_done(g, e);
        check_val("post_edges", e, 32);
        check_val("post_done", o_done, 2'b10);
        wait_idle(e);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vsc8541_smi_ctrl.md
# vsc8541_smi_ctrl

Arbitrating sequencer for the VSC8541 SMI management path. Sits between several register-access requesters and the single `vsc8541_smi_mdio` frame engine, which is clocked by `vsc8541_smi_mdc_gen`. The block grants one requester at a time round-robin, launches its frame, tracks completion on MDC edges, and returns read data or a timeout error. Optionally it also polls PHY link status autonomously.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (1..8).
- `WR_EDGES`, 32: MDC falling edges after launch that complete a write frame.
- `RD_TIMEOUT`, 64: MDC falling edges without `i_mdio_dv` before a read aborts.
- `GAP_EDGES`, 2: idle MDC falling edges enforced between frames.
- `POLL_INTERVAL`, 1_000_000: clk cycles between link polls (POLL build only).
- `POLL_PHY_ADDR`, 5'h00: PHY polled (POLL build only).

Ports:
- `clk`  in  1  system clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_mdc`  in  1  MDC from `vsc8541_smi_mdc_gen`, synchronous to `clk`.
- `i_req`  in  NREQ  per-requester request level.
- `i_req_mode`  in  NREQ  1 = write, 0 = read.
- `i_req_phy_addr`  in  NREQ×5  PHY address.
- `i_req_reg_addr`  in  NREQ×5  register address.
- `i_req_data`  in  NREQ×16  write data.
- `o_grant`  out  NREQ  one-hot, 1-cycle pulse; request accepted.
- `o_done`  out  NREQ  one-hot, 1-cycle pulse; access finished.
- `o_rdata`  out  16  read data, valid with `o_done`.
- `o_err`  out  1  read timeout, valid with `o_done`.
- `o_busy`  out  1  high when not IDLE.
- `o_mdio_en`, `o_mdio_mode`, `o_mdio_phy_addr[4:0]`, `o_mdio_reg_addr[4:0]`, `o_mdio_data[15:0]`  out: engine command.
- `i_mdio_dv`  in  1; `i_mdio_data`  in  16: engine read result.
- `o_link_up`  out  1  status reg 1 bit 2 (POLL build only).

## Operation
- States: IDLE → LAUNCH → WAIT → GAP → IDLE.
- IDLE: if any `i_req` bit is high, select the first set bit at or after `rr_ptr`, cyclically. Latch its mode, addresses and data. Go to LAUNCH.
- LAUNCH (one cycle):
  - Pulse `o_grant[sel]` and `o_mdio_en`.
  - Drive the latched fields on `o_mdio_*`; they stay stable until IDLE.
  - Set `rr_ptr = sel+1 mod NREQ`.
  - Clear the edge counter. Go to WAIT.
- WAIT, write: count MDC falling edges, detected as registered `mdc_q & ~i_mdc`. At `WR_EDGES`, pulse `o_done[sel]` and go to GAP.
- WAIT, read:
  - On `i_mdio_dv`: capture `i_mdio_data` into `o_rdata`, pulse `o_done[sel]` with `o_err=0`, go to GAP.
  - If the edge count reaches `RD_TIMEOUT` first: pulse `o_done[sel]` with `o_err=1`, `o_rdata` holds its old value, go to GAP.
- GAP: count `GAP_EDGES` falling edges, then go to IDLE.
- Requester rule: hold `i_req` and fields until its `o_grant`, then drop or re-raise `i_req`. A request still high after `o_done` is a new access.
- `i_mdio_dv` arriving in a write frame or outside WAIT is ignored.
- Edge counter is 8 bits and saturates.

## Timing
- Reset values:
  - `o_grant`, `o_done`, `o_mdio_en`, `o_err`, `o_busy`, `o_link_up`: 0.
  - `o_rdata`, `o_mdio_*` fields: 0.
  - `rr_ptr` 0, state IDLE.
- Latency:
  - `i_req` high in IDLE → `o_grant` and `o_mdio_en` 2 clk later (select, then LAUNCH).
  - `i_mdio_dv` → `o_done` next clk.
- `o_busy` is high from the cycle after IDLE selects through the last GAP cycle.
- Simultaneous requests are granted in round-robin order. A single persistent requester is re-granted after each GAP.
- Reset mid-frame aborts at once: no `o_done` for the aborted access. The engine shares `i_reset`.

## Configuration
- `VSC8541_SMI_CTRL_POLL_EN` defined:
  - An internal poll requester has lowest priority, below all external requesters and outside the rotation.
  - It arms every `POLL_INTERVAL` clk cycles and reads reg 5'h01 of `POLL_PHY_ADDR`.
  - On a successful read, `o_link_up` takes `rdata[2]`. On timeout, `o_link_up` is forced to 0.
  - Poll frames never pulse `o_grant` or `o_done`.
- Undefined: no poll logic, and `o_link_up` is tied to 0.

## Structure
- Package `vsc8541_smi_pkg`:
  - state enum.
  - `SMI_REG_STATUS = 5'h01`, `SMI_LINK_BIT = 2`.
  - field-width constants, shared with the mdio engine.
- Sub-module `vsc8541_smi_rr_arb`: combinational round-robin pick from the request vector and `rr_ptr`, returning a one-hot grant and an index.

## Test plan
- Single write, req0 to PHY 5'h05 / reg 5'h1b with data 16'ha55a:
  - `o_grant[0]` arrives 2 clk after req.
  - `o_mdio_*` match the request.
  - `o_done[0]` comes after 32 MDC falling edges.
- Read, req1 to PHY 5'h05 / reg 5'h1b, model returns 16'h5aa5 via `i_mdio_dv`: `o_done[1]` with `o_rdata=16'h5aa5` and `o_err=0`.
- Read with no `i_mdio_dv`: `o_done` with `o_err=1` after 64 falling edges, and `o_rdata` unchanged.
- req0 and req1 held high together for 4 accesses: grant order is 0, 1, 0, 1, with a GAP of 2 MDC edges between frames.
- `i_reset` asserted mid-WAIT:
  - all outputs return to their reset values the next clk.
  - no `o_done` for the aborted access.
  - the next request is granted normally.
- POLL build, `POLL_INTERVAL=2000`, model returns 16'h0004 then 16'h0000:
  - `o_link_up` goes 1, then 0.
  - no `o_grant` or `o_done` pulses.
